// File: rtl/gaussian_filter_pipe_if.sv
// Valid/ready bundle carrying a KxK pixel window in and one filtered pixel out.
// The master side is the surrounding environment; the filter connects as slave.
interface gaussian_filter_pipe_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3
);
    localparam int INPUT_WIDTH = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE;

    logic                   in_valid;
    logic                   in_ready;
    logic [INPUT_WIDTH-1:0] kernel;
    logic                   mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  data_out;

    modport master (
        output in_valid,
        output kernel,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  kernel,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );
endinterface

// File: rtl/gaussian_filter_pipe.sv
// Three-stage separable binomial (Gaussian) smoother with per-beat bypass and
// full valid/ready backpressure: S1 row sums, S2 column sum, S3 rounding.
module gaussian_filter_pipe #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  KERNEL_SIZE = 3,
    localparam int INPUT_WIDTH = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE,
    localparam int SHIFT       = 2 * (KERNEL_SIZE - 1),
    localparam int ACC_WIDTH   = DATA_WIDTH + SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    gaussian_filter_pipe_if.slave bus
);

    localparam int ROW_WIDTH = DATA_WIDTH + KERNEL_SIZE - 1;
    localparam int CENTRE    = (KERNEL_SIZE / 2) * KERNEL_SIZE + (KERNEL_SIZE / 2);
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS =
        {{(ACC_WIDTH - 1){1'b0}}, 1'b1} << (SHIFT - 1);

    if ((KERNEL_SIZE != 3) && (KERNEL_SIZE != 5)) begin : g_bad_kernel
        $error("gaussian_filter_pipe: KERNEL_SIZE must be 3 or 5");
    end

    // Five tap slots regardless of K so the shared adder tree never indexes out of range.
    typedef logic [4:0][ACC_WIDTH-1:0] taps_t;

    // Binomial weighted sum built from shifts and adds only (1-2-1 or 1-4-6-4-1).
    function automatic logic [ACC_WIDTH-1:0] binom_sum(input taps_t taps);
        logic [ACC_WIDTH-1:0] sum;
        if (KERNEL_SIZE == 5) begin
            sum = taps[0] + (taps[1] << 3'd2) + (taps[2] << 3'd2) + (taps[2] << 3'd1)
                + (taps[3] << 3'd2) + taps[4];
        end else begin
            sum = taps[0] + (taps[1] << 3'd1) + taps[2];
        end
        return sum;
    endfunction

    logic                                  s1_valid_r;
    logic [KERNEL_SIZE-1:0][ROW_WIDTH-1:0] s1_row_r;
    logic                                  s1_mode_r;
    logic [DATA_WIDTH-1:0]                 s1_centre_r;

    logic                                  s2_valid_r;
    logic [ACC_WIDTH-1:0]                  s2_acc_r;
    logic                                  s2_mode_r;
    logic [DATA_WIDTH-1:0]                 s2_centre_r;

    logic                                  s3_valid_r;
    logic [DATA_WIDTH-1:0]                 s3_data_r;

    logic                                  ready1_s;
    logic                                  ready2_s;
    logic                                  ready3_s;

    taps_t                                 h_taps_s;
    logic [ACC_WIDTH-1:0]                  h_sum_s;
    logic [KERNEL_SIZE-1:0][ROW_WIDTH-1:0] row_sum_s;
    taps_t                                 v_taps_s;
    logic [ACC_WIDTH-1:0]                  col_sum_s;
    logic [ACC_WIDTH-1:0]                  rounded_s;
    logic [DATA_WIDTH-1:0]                 result_s;

    // Backward ready chain: a stage can load when empty or when its contents advance.
    always_comb begin
        ready3_s = !s3_valid_r || bus.out_ready;
        ready2_s = !s2_valid_r || ready3_s;
        ready1_s = !s1_valid_r || ready2_s;
    end

    // Horizontal pass: one binomial sum per window row.
    always_comb begin
        h_taps_s  = '0;
        h_sum_s   = '0;
        row_sum_s = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            h_taps_s = '0;
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                h_taps_s[c] = ACC_WIDTH'(bus.kernel[(r * KERNEL_SIZE + c) * DATA_WIDTH +: DATA_WIDTH]);
            end
            h_sum_s      = binom_sum(h_taps_s);
            row_sum_s[r] = h_sum_s[ROW_WIDTH-1:0];
        end
    end

    // Vertical pass over the registered row sums.
    always_comb begin
        v_taps_s = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            v_taps_s[r] = ACC_WIDTH'(s1_row_r[r]);
        end
        col_sum_s = binom_sum(v_taps_s);
    end

    // Round half up; the weights sum to 2^SHIFT so the result always fits DATA_WIDTH.
    always_comb begin
        rounded_s = s2_acc_r + ROUND_BIAS;
        if (s2_mode_r) begin
            result_s = s2_centre_r;
        end else begin
            result_s = rounded_s[SHIFT +: DATA_WIDTH];
        end
    end

    // Stage 1: capture row sums, mode and centre pixel of an accepted window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_row_r    <= '0;
            s1_mode_r   <= 1'b0;
            s1_centre_r <= '0;
        end else if (ready1_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_row_r    <= row_sum_s;
                s1_mode_r   <= bus.mode;
                s1_centre_r <= bus.kernel[CENTRE * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Stage 2: column sum plus the side-band carried alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_acc_r    <= '0;
            s2_mode_r   <= 1'b0;
            s2_centre_r <= '0;
        end else if (ready2_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_acc_r    <= col_sum_s;
                s2_mode_r   <= s1_mode_r;
                s2_centre_r <= s1_centre_r;
            end
        end
    end

    // Stage 3: output register; holds its pixel while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid_r <= 1'b0;
            s3_data_r  <= '0;
        end else if (ready3_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_data_r <= result_s;
            end
        end
    end

    assign bus.in_ready  = ready1_s;
    assign bus.out_valid = s3_valid_r;
    assign bus.data_out  = s3_data_r;

endmodule

// File: tb/tb_gaussian_filter_pipe.sv
// Directed plus random bench for gaussian_filter_pipe at K=3 and K=5, with a
// scoreboard queue per instance filled on accept and drained on output.
module tb_gaussian_filter_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gaussian_filter_pipe_if #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) bus3 ();
    gaussian_filter_pipe_if #(.DATA_WIDTH(8), .KERNEL_SIZE(5)) bus5 ();

    gaussian_filter_pipe #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    gaussian_filter_pipe #(.DATA_WIDTH(8), .KERNEL_SIZE(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int tests = 0;
    int fails = 0;
    logic [7:0] q3[$];
    logic [7:0] q5[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: direct 2-D weighted sum with multiplies, then round half up.
    function automatic logic [7:0] ref_pix(input int kk, input logic [199:0] win, input logic m);
        int w[5];
        int sum;
        int sh;
        int ctr;
        if (kk == 5) w = '{1, 4, 6, 4, 1};
        else         w = '{1, 2, 1, 0, 0};
        sh  = 2 * (kk - 1);
        ctr = (kk / 2) * kk + kk / 2;
        sum = 0;
        for (int r = 0; r < kk; r++)
            for (int c = 0; c < kk; c++)
                sum += w[r] * w[c] * int'(win[(r * kk + c) * 8 +: 8]);
        if (m) return win[ctr * 8 +: 8];
        return 8'((sum + (1 << (sh - 1))) >> sh);
    endfunction

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] w;
        for (int p = 0; p < 25; p++) w[p * 8 +: 8] = v;
        return w;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send3(input logic [199:0] w, input logic m, input logic [7:0] exp);
        int waited;
        waited = 0;
        bus3.in_valid = 1'b1;
        bus3.kernel   = w[71:0];
        bus3.mode     = m;
        @(negedge clk);
        while (bus3.in_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("send3_accept", 32'(bus3.in_ready), 32'd1);
        if (bus3.in_ready === 1'b1) q3.push_back(exp);
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
    endtask

    task automatic send5(input logic [199:0] w, input logic m, input logic [7:0] exp);
        int waited;
        waited = 0;
        bus5.in_valid = 1'b1;
        bus5.kernel   = w;
        bus5.mode     = m;
        @(negedge clk);
        while (bus5.in_ready !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("send5_accept", 32'(bus5.in_ready), 32'd1);
        if (bus5.in_ready === 1'b1) q5.push_back(exp);
        @(posedge clk); #1;
        bus5.in_valid = 1'b0;
    endtask

    // Counts cycles from the accept cycle until out_valid rises.
    task automatic latency3(input string tag);
        int lat;
        lat = 1;
        @(negedge clk);
        while (bus3.out_valid !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check(tag, lat, 32'd3);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a transfer happens at the next edge when both flags are high.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst === 1'b0 && bus3.out_valid === 1'b1 && bus3.out_ready === 1'b1) begin
            if (q3.size() == 0) begin
                check("mon3_spurious", 32'(bus3.out_valid), 32'd0);
            end else begin
                e = q3.pop_front();
                check("mon3_data", 32'(bus3.data_out), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst === 1'b0 && bus5.out_valid === 1'b1 && bus5.out_ready === 1'b1) begin
            if (q5.size() == 0) begin
                check("mon5_spurious", 32'(bus5.out_valid), 32'd0);
            end else begin
                e = q5.pop_front();
                check("mon5_data", 32'(bus5.data_out), 32'(e));
            end
        end
    end

    logic [199:0] w;
    logic         m;
    logic [7:0]   t5_vals [5];
    int           idx;
    int           run_len;

    initial begin
        bus3.in_valid = 1'b0; bus3.kernel = '0; bus3.mode = 1'b0; bus3.out_ready = 1'b1;
        bus5.in_valid = 1'b0; bus5.kernel = '0; bus5.mode = 1'b0; bus5.out_ready = 1'b1;
        t5_vals = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid3", 32'(bus3.out_valid), 32'd0);
        check("rst_in_ready3",  32'(bus3.in_ready),  32'd1);
        check("rst_data_out3",  32'(bus3.data_out),  32'd0);
        check("rst_out_valid5", 32'(bus5.out_valid), 32'd0);
        rst = 1'b0;
        idle(1);

        // T1: flat 200 window, value and latency
        send3(fill(8'd200), 1'b0, 8'd200);
        latency3("t1_latency");

        // T2: impulse at centre and at a corner
        w = fill(8'd0); w[4 * 8 +: 8] = 8'd255;
        send3(w, 1'b0, 8'd64);
        w = fill(8'd0); w[0 +: 8] = 8'd255;
        send3(w, 1'b0, 8'd16);
        idle(5);

        // T3: K=5 saturation-free flat window and centre impulse
        send5(fill(8'd255), 1'b0, 8'd255);
        w = fill(8'd0); w[12 * 8 +: 8] = 8'd255;
        send5(w, 1'b0, 8'd36);
        idle(5);

        // T4: bypass, then mode interleaved on consecutive beats
        w = fill(8'd250); w[4 * 8 +: 8] = 8'd17;
        send3(w, 1'b1, 8'd17);
        w = fill(8'd100); w[4 * 8 +: 8] = 8'd40;
        send3(w, 1'b0, ref_pix(3, w, 1'b0));
        send3(w, 1'b1, 8'd40);
        send3(w, 1'b0, ref_pix(3, w, 1'b0));
        w = fill(8'd100); w[12 * 8 +: 8] = 8'd40;
        send5(w, 1'b1, 8'd40);
        send5(w, 1'b0, ref_pix(5, w, 1'b0));
        idle(6);

        // Random windows and modes on both kernel sizes
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 25; p++) w[p * 8 +: 8] = 8'($urandom_range(0, 255));
            m = 1'($urandom_range(0, 1));
            send3(w, m, ref_pix(3, w, m));
            send5(w, m, ref_pix(5, w, m));
        end
        idle(6);

        // T5: stall for 6 cycles while offering 10..50 back to back
        idx = 0;
        bus3.out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus3.in_valid = 1'b1;
            bus3.kernel   = fill(t5_vals[idx])[71:0];
            bus3.mode     = 1'b0;
            @(negedge clk);
            if (bus3.in_ready === 1'b1) begin
                q3.push_back(t5_vals[idx]);
                idx++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("t5_accepts",   idx, 32'd3);
        check("t5_in_ready",  32'(bus3.in_ready),  32'd0);
        check("t5_out_valid", 32'(bus3.out_valid), 32'd1);
        check("t5_hold_data", 32'(bus3.data_out),  32'd10);
        @(posedge clk); #1;
        bus3.out_ready = 1'b1;
        run_len = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (idx < 5) begin
                bus3.in_valid = 1'b1;
                bus3.kernel   = fill(t5_vals[idx])[71:0];
            end else begin
                bus3.in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) check("t5_release_ready", 32'(bus3.in_ready), 32'd1);
            if (bus3.out_valid === 1'b1) run_len++;
            if (bus3.in_valid === 1'b1 && bus3.in_ready === 1'b1) begin
                q3.push_back(t5_vals[idx]);
                idx++;
            end
            @(posedge clk); #1;
        end
        bus3.in_valid = 1'b0;
        check("t5_all_accepted", idx, 32'd5);
        check("t5_no_gaps", run_len, 32'd5);
        idle(4);

        // T6: reset with two beats in flight
        bus3.out_ready = 1'b0;
        send3(fill(8'd77), 1'b0, 8'd77);
        send3(fill(8'd88), 1'b0, 8'd88);
        idle(1);
        check("t6_inflight_valid", 32'(bus3.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_out_valid", 32'(bus3.out_valid), 32'd0);
        check("t6_async_data_out",  32'(bus3.data_out),  32'd0);
        q3.delete();
        q5.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        check("t6_in_ready",  32'(bus3.in_ready),  32'd1);
        check("t6_out_valid", 32'(bus3.out_valid), 32'd0);
        @(posedge clk); #1;
        send3(fill(8'd123), 1'b0, 8'd123);
        latency3("t6_latency");
        idle(6);

        check("q3_drained", q3.size(), 32'd0);
        check("q5_drained", q5.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
